// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing defaults, counter widths, pixel
// types and the fixed 16-entry IRGB palette.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_CNT_W  = 10;
  localparam int V_CNT_W  = 10;
  localparam int RGB_W    = 12;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef logic [3:0]       pal_idx_t;

  typedef struct packed {
    logic [H_CNT_W-1:0] x_start;
    logic [H_CNT_W-1:0] x_end;
    logic [V_CNT_W-1:0] y_start;
    logic [V_CNT_W-1:0] y_end;
    pal_idx_t           color;
  } char_box_t;

  // Bit 3 selects full (F) or half (8) intensity for each enabled channel;
  // index 8 has no channel bits and is defined as dark grey.
  function automatic rgb_t palette(input pal_idx_t idx);
    logic [3:0] lvl;
    lvl = idx[3] ? 4'hF : 4'h8;
    if (idx == 4'h8) begin
      palette = 12'h444;
    end else begin
      palette = {idx[2] ? lvl : 4'h0, idx[1] ? lvl : 4'h0, idx[0] ? lvl : 4'h0};
    end
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running horizontal/vertical counters with combinational sync, data-enable
// and frame-start decode; the consumer registers these alongside its pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_pkg::H_FP,
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BP     = vga_pkg::H_BP,
  parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_pkg::V_FP,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BP     = vga_pkg::V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [H_CNT_W-1:0] h_cnt,
  output logic [V_CNT_W-1:0] v_cnt,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               frame_strobe
);

  localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [H_CNT_W-1:0] H_VIS    = H_CNT_W'(H_ACTIVE);
  localparam logic [V_CNT_W-1:0] V_VIS    = V_CNT_W'(V_ACTIVE);
  localparam logic [H_CNT_W-1:0] HS_START = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] HS_END   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CNT_W-1:0] VS_START = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] VS_END   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign hsync        = (h_cnt >= HS_START && h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
  assign vsync        = (v_cnt >= VS_START && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
  assign de           = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign frame_strobe = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_char_render.sv
// VGA character-box renderer: paints one palette-coloured rectangle over the
// background. Define VGA_CHAR_SHADOW_EN to latch the box once per frame.
module vga_char_render
  import vga_pkg::*;
#(
  parameter int       H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int       H_FP     = vga_pkg::H_FP,
  parameter int       H_SYNC   = vga_pkg::H_SYNC,
  parameter int       H_BP     = vga_pkg::H_BP,
  parameter int       V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int       V_FP     = vga_pkg::V_FP,
  parameter int       V_SYNC   = vga_pkg::V_SYNC,
  parameter int       V_BP     = vga_pkg::V_BP,
  parameter logic     SYNC_POL = 1'b0,
  parameter pal_idx_t BG_COLOR = 4'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [H_CNT_W-1:0] char_x_start,
  input  logic [H_CNT_W-1:0] char_x_end,
  input  logic [V_CNT_W-1:0] char_y_start,
  input  logic [V_CNT_W-1:0] char_y_end,
  input  logic [3:0]         char_color,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [RGB_W-1:0]   rgb,
  output logic               frame_start
);

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               hsync_pre;
  logic               vsync_pre;
  logic               de_pre;
  logic               frame_pre;
  char_box_t          live_box;
  char_box_t          box;
  logic               hit;
  pal_idx_t           pix_idx;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .hsync        (hsync_pre),
    .vsync        (vsync_pre),
    .de           (de_pre),
    .frame_strobe (frame_pre)
  );

  assign live_box = '{
    x_start: char_x_start,
    x_end:   char_x_end,
    y_start: char_y_start,
    y_end:   char_y_end,
    color:   char_color
  };

`ifdef VGA_CHAR_SHADOW_EN
  localparam logic [H_CNT_W-1:0] H_LAST = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [V_CNT_W-1:0] V_LAST = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  char_box_t shadow_box;
  logic      first_q;
  logic      wrap;

  assign wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // The first cycle after reset release both renders pixel (0,0) and loads the
  // shadow, so it bypasses the still-cleared shadow copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_box <= '0;
      first_q    <= 1'b1;
    end else begin
      first_q <= 1'b0;
      if (first_q || wrap) begin
        shadow_box <= live_box;
      end
    end
  end

  assign box = first_q ? live_box : shadow_box;
`else
  assign box = live_box;
`endif

  // An inverted range on either axis can never satisfy both compares.
  assign hit = (h_cnt >= box.x_start) && (h_cnt <= box.x_end) &&
               (v_cnt >= box.y_start) && (v_cnt <= box.y_end);

  assign pix_idx = hit ? box.color : BG_COLOR;

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hsync_pre;
      vsync       <= vsync_pre;
      de          <= de_pre;
      rgb         <= de_pre ? palette(pix_idx) : '0;
      frame_start <= frame_pre;
    end
  end

endmodule

// File: tb/tb_vga_char_render.sv
// Directed bench for vga_char_render: full 800-pixel lines with a shortened
// vertical frame (17 lines) so several frames fit in a short run.
module tb_vga_char_render;

  localparam int H_TOT = 800;
  localparam int V_ACT = 12;
  localparam int V_FP  = 2;
  localparam int V_SY  = 2;
  localparam int V_BP  = 1;
  localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  char_x_start;
  logic [9:0]  char_x_end;
  logic [9:0]  char_y_start;
  logic [9:0]  char_y_end;
  logic [3:0]  char_color;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [11:0] rgb;
  logic        frame_start;

  always #5 clk = ~clk;

  vga_char_render #(
    .V_ACTIVE (V_ACT),
    .V_FP     (V_FP),
    .V_SYNC   (V_SY),
    .V_BP     (V_BP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .char_x_start (char_x_start),
    .char_x_end   (char_x_end),
    .char_y_start (char_y_start),
    .char_y_end   (char_y_end),
    .char_color   (char_color),
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de),
    .rgb          (rgb),
    .frame_start  (frame_start)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Expected box as currently visible on the output, and its colour.
  int          pos;
  int          m_xs, m_xe, m_ys, m_ye;
  logic [11:0] m_rgb;

  int bad_de, bad_hs, bad_vs, bad_fs, bad_rgb;
  int n_de, n_hs, n_vs, n_fs, fs_first, fs_last, fs_gap_bad;
  int n_f00, n_080, n_00f;

  task automatic clear_stats();
    bad_de = 0; bad_hs = 0; bad_vs = 0; bad_fs = 0; bad_rgb = 0;
    n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0; fs_first = -1; fs_last = 0; fs_gap_bad = 0;
    n_f00 = 0; n_080 = 0; n_00f = 0;
  endtask

  task automatic set_box(input int xs, input int xe, input int ys, input int ye,
                         input logic [3:0] color, input logic [11:0] exp_rgb);
    char_x_start = 10'(xs);
    char_x_end   = 10'(xe);
    char_y_start = 10'(ys);
    char_y_end   = 10'(ye);
    char_color   = color;
    m_xs = xs; m_xe = xe; m_ys = ys; m_ye = ye;
    m_rgb = exp_rgb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      int          h;
      int          v;
      logic        e_de, e_hs, e_vs, e_fs, hit;
      logic [11:0] e_rgb;
      step();
      h     = pos % H_TOT;
      v     = (pos / H_TOT) % V_TOT;
      e_de  = (h < 640) && (v < V_ACT);
      e_hs  = !((h >= 656) && (h < 752));
      e_vs  = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SY));
      e_fs  = (pos % FRAME) == 0;
      hit   = (h >= m_xs) && (h <= m_xe) && (v >= m_ys) && (v <= m_ye);
      e_rgb = (e_de && hit) ? m_rgb : 12'h000;
      if (de !== e_de) bad_de++;
      if (hsync !== e_hs) bad_hs++;
      if (vsync !== e_vs) bad_vs++;
      if (frame_start !== e_fs) bad_fs++;
      if (rgb !== e_rgb) bad_rgb++;
      if (de === 1'b1) n_de++;
      if (hsync === 1'b0) n_hs++;
      if (vsync === 1'b0) n_vs++;
      if (frame_start === 1'b1) begin
        if (n_fs == 0) fs_first = pos;
        else if (pos - fs_last != FRAME) fs_gap_bad++;
        n_fs++;
        fs_last = pos;
      end
      if (rgb === 12'hF00) n_f00++;
      if (rgb === 12'h080) n_080++;
      if (rgb === 12'h00F) n_00f++;
      pos++;
    end
  endtask

  initial begin
    rst = 1'b1;
    pos = 0;
    set_box(10, 19, 5, 7, 4'hC, 12'hF00);
    clear_stats();
    repeat (3) step();
    check("reset hsync", 32'(hsync), 32'd1);
    check("reset vsync", 32'(vsync), 32'd1);
    check("reset de", 32'(de), 32'd0);
    check("reset rgb", 32'(rgb), 32'h000);
    check("reset frame_start", 32'(frame_start), 32'd0);

    // Two frames of the red box at x 10..19, y 5..7.
    rst = 1'b0;
    pos = 0;
    run(2 * FRAME - 10);
    set_box(20, 10, 5, 7, 4'hC, 12'hF00);
    run(10);
    check("frame_start count", 32'(n_fs), 32'd2);
    check("first frame_start pos", 32'(fs_first), 32'd0);
    check("frame_start period", 32'(fs_gap_bad), 32'd0);
    check("frame_start timing", 32'(bad_fs), 32'd0);
    check("de timing", 32'(bad_de), 32'd0);
    check("hsync timing", 32'(bad_hs), 32'd0);
    check("vsync timing", 32'(bad_vs), 32'd0);
    check("de cycles", 32'(n_de), 32'(2 * 640 * V_ACT));
    check("hsync low cycles", 32'(n_hs), 32'(2 * 96 * V_TOT));
    check("vsync low cycles", 32'(n_vs), 32'(2 * 1600));
    check("box rgb stream", 32'(bad_rgb), 32'd0);
    check("box pixel count", 32'(n_f00), 32'd60);

    // Inverted x range: nothing painted.
    clear_stats();
    run(FRAME - 10);
    set_box(630, 700, 5, 7, 4'hC, 12'hF00);
    run(10);
    check("inverted box pixels", 32'(n_f00), 32'd0);
    check("inverted box rgb stream", 32'(bad_rgb), 32'd0);

    // Box past the right edge: only columns 630..639 visible.
    clear_stats();
    run(FRAME - 10);
    set_box(10, 19, 5, 10, 4'h2, 12'h080);
    run(10);
    check("clipped box pixels", 32'(n_f00), 32'd30);
    check("clipped box rgb stream", 32'(bad_rgb), 32'd0);

    // Colour change from green to bright blue at the start of line 8.
    clear_stats();
    run(8 * H_TOT);
    char_color = 4'h9;
`ifndef VGA_CHAR_SHADOW_EN
    m_rgb = 12'h00F;
`endif
    run(FRAME - 8 * H_TOT);
`ifdef VGA_CHAR_SHADOW_EN
    check("mid-frame green pixels", 32'(n_080), 32'd60);
    check("mid-frame blue pixels", 32'(n_00f), 32'd0);
    m_rgb = 12'h00F;
`else
    check("mid-frame green pixels", 32'(n_080), 32'd30);
    check("mid-frame blue pixels", 32'(n_00f), 32'd30);
`endif
    check("mid-frame rgb stream", 32'(bad_rgb), 32'd0);

    // Next frame up to line 10 shows the blue box on lines 5..9.
    clear_stats();
    run(10 * H_TOT);
    check("next frame blue pixels", 32'(n_00f), 32'd50);
    check("next frame rgb stream", 32'(bad_rgb), 32'd0);

    // Mid-frame reset with a one-pixel box at (0,0).
    set_box(0, 0, 0, 0, 4'hC, 12'hF00);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid-frame reset idle", 32'({hsync, vsync, de, rgb, frame_start}), 32'({1'b1, 1'b1, 1'b0, 12'h000, 1'b0}));
    end
    rst = 1'b0;
    pos = 0;
    clear_stats();
    run(1);
    check("post-reset frame_start", 32'(frame_start), 32'd1);
    check("post-reset de", 32'(de), 32'd1);
    check("post-reset pixel 0,0", 32'(rgb), 32'hF00);
    run(H_TOT + 5);
    check("post-reset timing", 32'(bad_de + bad_hs + bad_vs + bad_fs), 32'd0);
    check("post-reset rgb stream", 32'(bad_rgb), 32'd0);
    check("single pixel box count", 32'(n_f00), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_char_render.md
Name: vga_char_render

Overview:
- Downstream consumer of the VGA CSR block's character-box outputs (char_x_start/end, char_y_start/end, char_color).
- Generates 640x480@60 Hz VGA timing (hsync, vsync, data-enable) from free-running horizontal/vertical counters.
- Paints an axis-aligned rectangle in the palette colour selected by char_color over a background colour.
- Output is one registered pixel stream for the DAC/pad stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- BG_COLOR, 4'h0, palette index for background inside the active area

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- char_x_start  in  10  box left column, inclusive
- char_x_end  in  10  box right column, inclusive
- char_y_start  in  10  box top line, inclusive
- char_y_end  in  10  box bottom line, inclusive
- char_color  in  4  palette index for box pixels
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  active-video enable
- rgb  out  12  pixel {R[3:0],G[3:0],B[3:0]}
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0)

Behaviour:
- Interface fixed: one clock (clk); reset rst is synchronous and active-high.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (800) and wraps to 0.
  - v_cnt increments when h_cnt wraps; it runs 0..V_TOTAL-1 (525) and wraps to 0.
  - H_TOTAL = sum of the four H_* parameters; V_TOTAL likewise.
- Reset:
  - Counters go to (0,0).
  - Outputs: hsync = vsync = ~SYNC_POL (idle level); de = 0; rgb = 12'h000; frame_start = 0.
  - Reset asserted mid-frame aborts the frame; counting restarts at (0,0) the cycle after rst deasserts.
- Latency:
  - All outputs are registered, one cycle after the counter value they describe.
  - The first output cycle after reset release shows pixel (0,0) with frame_start = 1.
- Sync decode:
  - hsync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Box hit: x_start <= h_cnt <= x_end && y_start <= v_cnt <= y_end. Unsigned 10-bit compares, both bounds inclusive.
- Box boundary cases:
  - start > end on either axis: no box drawn.
  - Bounds beyond the active area: clipped by de.
  - start == end: box is one pixel wide/tall.
- rgb = de ? palette(hit ? char_color : BG_COLOR) : 12'h000.
- Palette (fixed IRGB, in the shared package):
  - Index bit3 = intensity; bits 2:0 = R, G, B.
  - Each enabled channel = 4'hF if bit3, else 4'h8.
  - Index 0 = black (12'h000); index 8 = grey 12'h444.
- frame_start = 1 only for the output cycle of h_cnt == 0 && v_cnt == 0.

Optional Feature:
- Macro: VGA_CHAR_SHADOW_EN.
- Defined:
  - The five char inputs are captured into shadow registers on the clock edge where the counters move from (H_TOTAL-1, V_TOTAL-1) to (0,0), and on reset release.
  - Shadow registers reset to 0.
  - Hit logic uses the shadows, so CSR writes take effect only from the next frame (no tearing).
- Undefined:
  - Hit logic uses the inputs directly.
  - A mid-frame change affects pixels from the next cycle's counter value onward.

Decomposition:
- Package vga_pkg holds:
  - timing defaults (H_*/V_* constants, H_TOTAL, V_TOTAL);
  - counter widths;
  - the 16-entry palette function/constant array;
  - the rgb type width (12).
- One natural sub-module, vga_timing_gen:
  - contains the counters plus sync/de decode;
  - exports h_cnt, v_cnt, pre-register hsync/vsync/de and the frame-start strobe.
- The top level adds box compare, palette lookup, optional shadowing and output registers.

Test Plan:
- Reset release, run 2 frames -> frame_start pulses exactly every 420000 cycles; first pulse in cycle 1 after release.
- Monitor per line -> hsync low for exactly 96 cycles starting 656 cycles after the de rising edge; de high 640 cycles per line, 480 lines per frame; vsync low for 2 lines (1600 cycles).
- Box x = 10..19, y = 5..7, char_color = 4'hC -> rgb = 12'hF00 for exactly 30 pixels at those coordinates; elsewhere in the active area rgb = 12'h000; blanking always 12'h000.
- Box x_start = 20, x_end = 10 -> no box pixels in the frame. Box x = 630..700 -> only columns 630..639 are painted.
- With VGA_CHAR_SHADOW_EN, change char_color from 4'h2 to 4'h9 at line 100 -> the whole current frame shows 12'h080 box pixels; the next frame shows 12'h00F. Without the macro, the change appears from line 100.
- Assert rst at line 200, hold 3 cycles -> outputs at idle levels during reset; frame_start one cycle after release; pixel (0,0) follows.
